// File: rtl/pipe_stage_buf.sv
// Pipeline stage register with 2-entry skid buffer; payload + BD/ExcCode sidecar. Optional counters: PIPE_STAGE_PERF_EN.
// Latency 1 cycle accept->out_valid; 1 entry/cycle while out_ready stays high.
// Backpressure: in_ready is a pure flop (~skid valid); one extra entry is absorbed when downstream stalls.
module pipe_stage_buf #(
    parameter int DATA_W = 64,
    parameter int EXC_W  = 5,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_bd,
    input  logic [EXC_W-1:0]  in_exc,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              out_bd,
    output logic [EXC_W-1:0]  out_exc
`ifdef PIPE_STAGE_PERF_EN
    ,
    output logic [CNT_W-1:0]  perf_stall,
    output logic [CNT_W-1:0]  perf_bubble,
    output logic [CNT_W-1:0]  perf_xfer
`endif
);

    typedef struct packed {
        logic [DATA_W-1:0] dat;
        logic              bd;
        logic [EXC_W-1:0]  exc;
    } ent_t;

    // Occupancy view derived from the valid bits; there is no separate state register.
    typedef enum logic [1:0] {ST_EMPTY, ST_FULL, ST_SKID} state_e;

    ent_t   main_q, main_d, skid_q, skid_d, in_ent;
    logic   main_v_q, main_v_d, skid_v_q, skid_v_d;
    state_e st;

    assign in_ent = {in_data, in_bd, in_exc};

    always_comb begin
        main_d   = main_q;
        skid_d   = skid_q;
        main_v_d = main_v_q;
        skid_v_d = skid_v_q;
        st       = skid_v_q ? ST_SKID : (main_v_q ? ST_FULL : ST_EMPTY);
        case (st)
            ST_EMPTY: begin
                if (in_valid) begin
                    main_d   = in_ent;
                    main_v_d = 1'b1;
                end
            end
            ST_FULL: begin
                if (out_ready) begin
                    if (in_valid) main_d   = in_ent;
                    else          main_v_d = 1'b0;
                end else if (in_valid) begin
                    skid_d   = in_ent;
                    skid_v_d = 1'b1;
                end
            end
            ST_SKID: begin
                if (out_ready) begin
                    main_d   = skid_q;
                    skid_v_d = 1'b0;
                end
            end
            default: ;
        endcase
        // Flush overrides any handshake in the same cycle.
        if (flush) begin
            main_d   = '0;
            skid_d   = '0;
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_v_q <= 1'b0;
            skid_v_q <= 1'b0;
        end else begin
            main_q   <= main_d;
            skid_q   <= skid_d;
            main_v_q <= main_v_d;
            skid_v_q <= skid_v_d;
        end
    end

    assign in_ready  = ~skid_v_q;
    assign out_valid = main_v_q;
    assign out_data  = main_v_q ? main_q.dat : '0;
    assign out_bd    = main_v_q & main_q.bd;
    assign out_exc   = main_v_q ? main_q.exc : '0;

    if (CNT_W < 1) begin : g_cnt_w_invalid
    end

`ifdef PIPE_STAGE_PERF_EN
    logic [CNT_W-1:0] stall_q, bubble_q, xfer_q;

    // A handshake discarded by flush does not count as a transfer.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stall_q  <= '0;
            bubble_q <= '0;
            xfer_q   <= '0;
        end else begin
            if (main_v_q && !out_ready && !(&stall_q)) stall_q  <= stall_q + 1'b1;
            if (!main_v_q && !(&bubble_q))             bubble_q <= bubble_q + 1'b1;
            if (main_v_q && out_ready && !flush && !(&xfer_q)) xfer_q <= xfer_q + 1'b1;
        end
    end

    assign perf_stall  = stall_q;
    assign perf_bubble = bubble_q;
    assign perf_xfer   = xfer_q;
`endif

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Randomised + directed bench for pipe_stage_buf; scoreboard queue models stage occupancy and order.
module tb_pipe_stage_buf;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [63:0] in_data = '0;
    logic        in_bd = 1'b0;
    logic [4:0]  in_exc = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [63:0] out_data;
    logic        out_bd;
    logic [4:0]  out_exc;
`ifdef PIPE_STAGE_PERF_EN
    logic [31:0] perf_stall, perf_bubble, perf_xfer;
    int unsigned m_stall = 0, m_bubble = 0, m_xfer = 0;
`endif

    pipe_stage_buf #(.DATA_W(64), .EXC_W(5), .CNT_W(32)) dut (
        .clk(clk), .reset(reset), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .in_bd(in_bd), .in_exc(in_exc),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_bd(out_bd), .out_exc(out_exc)
`ifdef PIPE_STAGE_PERF_EN
        , .perf_stall(perf_stall), .perf_bubble(perf_bubble), .perf_xfer(perf_xfer)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [63:0] d;
        logic        bd;
        logic [4:0]  e;
    } ent_t;

    ent_t q[$];
    int   errors = 0;
    int   checks = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: held entries = queue contents; front of queue is what the stage must present.
    always @(negedge clk) begin
        logic exp_v, exp_rdy;
        if (!reset) begin
            q.delete();
            chk("rst_out_valid", {63'd0, out_valid}, 64'd0);
            chk("rst_in_ready",  {63'd0, in_ready},  64'd1);
            chk("rst_out_data",  out_data, 64'd0);
            chk("rst_out_side",  {58'd0, out_bd, out_exc}, 64'd0);
`ifdef PIPE_STAGE_PERF_EN
            m_stall = 0; m_bubble = 0; m_xfer = 0;
            chk("rst_perf", {perf_stall | perf_bubble | perf_xfer}, 64'd0);
`endif
        end else begin
            exp_v   = q.size() > 0;
            exp_rdy = q.size() < 2;
            chk("out_valid", {63'd0, out_valid}, {63'd0, exp_v});
            chk("in_ready",  {63'd0, in_ready},  {63'd0, exp_rdy});
            if (exp_v) begin
                chk("out_data", out_data, q[0].d);
                chk("out_side", {58'd0, out_bd, out_exc}, {58'd0, q[0].bd, q[0].e});
            end else begin
                chk("idle_data", out_data, 64'd0);
                chk("idle_side", {58'd0, out_bd, out_exc}, 64'd0);
            end
`ifdef PIPE_STAGE_PERF_EN
            chk("perf_stall",  {32'd0, perf_stall},  {32'd0, m_stall});
            chk("perf_bubble", {32'd0, perf_bubble}, {32'd0, m_bubble});
            chk("perf_xfer",   {32'd0, perf_xfer},   {32'd0, m_xfer});
            if (exp_v && !out_ready) m_stall++;
            if (!exp_v) m_bubble++;
            if (exp_v && out_ready && !flush) m_xfer++;
`endif
            if (flush) begin
                q.delete();
            end else begin
                if (exp_v && out_ready) void'(q.pop_front());
                if (in_valid && exp_rdy) q.push_back('{d: in_data, bd: in_bd, e: in_exc});
            end
        end
    end

    task automatic drive(input logic v, input logic [63:0] d, input logic bd, input logic [4:0] e,
                         input logic ordy, input logic fl);
        @(posedge clk);
        #1;
        in_valid = v; in_data = d; in_bd = bd; in_exc = e; out_ready = ordy; flush = fl;
    endtask

    task automatic idle(input int n, input logic ordy);
        for (int i = 0; i < n; i++) drive(1'b0, 64'd0, 1'b0, 5'd0, ordy, 1'b0);
    endtask

    task automatic async_reset_pulse();
        @(posedge clk);
        #3 reset = 1'b0;
        #1;
        chk("arst_out_valid", {63'd0, out_valid}, 64'd0);
        chk("arst_in_ready",  {63'd0, in_ready},  64'd1);
        chk("arst_out_data",  out_data, 64'd0);
        chk("arst_out_side",  {58'd0, out_bd, out_exc}, 64'd0);
`ifdef PIPE_STAGE_PERF_EN
        chk("arst_perf", {perf_stall | perf_bubble | perf_xfer}, 64'd0);
`endif
        @(posedge clk);
        #1 reset = 1'b1;
    endtask

    initial begin
        // Reset held, then released with nothing offered.
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        idle(3, 1'b1);

        // Back-to-back stream, no bubbles.
        drive(1'b1, 64'h11, 1'b0, 5'd0, 1'b1, 1'b0);
        drive(1'b1, 64'h22, 1'b0, 5'd0, 1'b1, 1'b0);
        drive(1'b1, 64'h33, 1'b0, 5'd0, 1'b1, 1'b0);
        idle(3, 1'b1);

        // Stall into skid, then drain in order.
        drive(1'b1, 64'hA1, 1'b0, 5'd0, 1'b0, 1'b0);
        drive(1'b1, 64'hA2, 1'b0, 5'd0, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(3, 1'b1);

        // Flush while in skid state with a new entry offered.
        drive(1'b1, 64'hB1, 1'b0, 5'd0, 1'b0, 1'b0);
        drive(1'b1, 64'hB2, 1'b0, 5'd0, 1'b0, 1'b0);
        drive(1'b1, 64'hB3, 1'b0, 5'd0, 1'b0, 1'b1);
        idle(3, 1'b1);

        // Exception sidecar travels with its payload.
        drive(1'b1, 64'hC0, 1'b1, 5'd12, 1'b0, 1'b0);
        idle(2, 1'b0);
        idle(2, 1'b1);

        // Perf-style sequence: stalls, flush, then async reset mid-stall.
        drive(1'b1, 64'hD1, 1'b1, 5'd7, 1'b0, 1'b0);
        drive(1'b1, 64'hD2, 1'b0, 5'd3, 1'b0, 1'b0);
        idle(3, 1'b0);
        drive(1'b0, 64'd0, 1'b0, 5'd0, 1'b1, 1'b1);
        idle(2, 1'b1);
        drive(1'b1, 64'hE1, 1'b1, 5'd9, 1'b0, 1'b0);
        drive(1'b1, 64'hE2, 1'b0, 5'd4, 1'b0, 1'b0);
        idle(1, 1'b0);
        async_reset_pulse();
        idle(2, 1'b1);

        // Randomised traffic with occasional flush and reset.
        for (int i = 0; i < 2000; i++) begin
            if (i % 500 == 250) async_reset_pulse();
            drive($urandom_range(0, 9) < 7, {$urandom, $urandom}, 1'($urandom_range(0, 1)),
                  5'($urandom_range(0, 31)), $urandom_range(0, 9) < 6, $urandom_range(0, 99) < 3);
        end
        idle(4, 1'b1);
        @(posedge clk);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
